// File: rtl/mockingboard_audio_conditioner.sv
// mockingboard_audio_conditioner: boxcar decimation, DC-blocking high-pass, volume and
// signed 16-bit saturation of the Mockingboard PSG sums, behind a one-deep valid/ready register.
module mockingboard_audio_conditioner #(
    parameter int DECIM_LOG2 = 4,
    parameter int DC_SHIFT   = 8,
    parameter int GAIN_SHIFT = 1
) (
    input  logic               clk_logic,
    input  logic               system_reset_n,
    input  logic               ce_i,
    input  logic               enable_i,
    input  logic [9:0]         audio_l_i,
    input  logic [9:0]         audio_r_i,
    input  logic [3:0]         vol_i,
    input  logic               dc_en_i,
    output logic signed [15:0] sample_l_o,
    output logic signed [15:0] sample_r_o,
    output logic               sample_valid_o,
    input  logic               sample_ready_i,
    output logic               overrun_o,
    input  logic               clear_overrun_i
);
    localparam int AW = 10 + DECIM_LOG2;
    localparam int DW = 10 + DC_SHIFT;

    logic [AW-1:0]         acc_l, acc_r, sum_l, sum_r;
    logic [DECIM_LOG2-1:0] cnt;
    logic [9:0]            avg_l, avg_r, dc_l, dc_r;
    logic                  avg_stb, hp_stb;
    logic [DW-1:0]         dc_acc_l, dc_acc_r;
    logic signed [10:0]    hp_l, hp_r, hpn_l, hpn_r;
    logic signed [15:0]    g_l, g_r;

    function automatic logic signed [15:0] gain(input logic signed [10:0] hp, input logic [3:0] vol);
        logic signed [31:0] hx, vx, p;
        hx = 32'(hp);
        vx = {28'b0, vol};
        p  = (hx * vx) <<< GAIN_SHIFT;
        return p > 32767 ? 16'sh7fff : p < -32768 ? 16'sh8000 : p[15:0];
    endfunction

    always_comb begin
        sum_l = acc_l + AW'(audio_l_i);
        sum_r = acc_r + AW'(audio_r_i);
        dc_l  = dc_acc_l[DW-1:DC_SHIFT];
        dc_r  = dc_acc_r[DW-1:DC_SHIFT];
        hpn_l = dc_en_i ? $signed({1'b0, avg_l}) - $signed({1'b0, dc_l}) : $signed({1'b0, avg_l});
        hpn_r = dc_en_i ? $signed({1'b0, avg_r}) - $signed({1'b0, dc_r}) : $signed({1'b0, avg_r});
        g_l   = gain(hp_l, vol_i);
        g_r   = gain(hp_r, vol_i);
    end

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            acc_l          <= '0;
            acc_r          <= '0;
            cnt            <= '0;
            avg_l          <= '0;
            avg_r          <= '0;
            avg_stb        <= 1'b0;
            dc_acc_l       <= '0;
            dc_acc_r       <= '0;
            hp_l           <= '0;
            hp_r           <= '0;
            hp_stb         <= 1'b0;
            sample_l_o     <= '0;
            sample_r_o     <= '0;
            sample_valid_o <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            avg_stb <= 1'b0;
            if (!enable_i) begin
                acc_l <= '0;
                acc_r <= '0;
                cnt   <= '0;
            end else if (ce_i) begin
                if (&cnt) begin
                    avg_l   <= sum_l[AW-1:DECIM_LOG2];
                    avg_r   <= sum_r[AW-1:DECIM_LOG2];
                    acc_l   <= '0;
                    acc_r   <= '0;
                    cnt     <= '0;
                    avg_stb <= 1'b1;
                end else begin
                    acc_l <= sum_l;
                    acc_r <= sum_r;
                    cnt   <= cnt + 1'b1;
                end
            end
            hp_stb <= avg_stb;
            if (avg_stb) begin
                hp_l <= hpn_l;
                hp_r <= hpn_r;
                // dc tracks avg with a 2^DC_SHIFT time constant; avg - dc can be negative
                if (dc_en_i) begin
                    dc_acc_l <= dc_acc_l + DW'(avg_l) - DW'(dc_l);
                    dc_acc_r <= dc_acc_r + DW'(avg_r) - DW'(dc_r);
                end
            end
            if (hp_stb) begin
                sample_l_o     <= g_l;
                sample_r_o     <= g_r;
                sample_valid_o <= 1'b1;
            end else if (sample_ready_i) begin
                sample_valid_o <= 1'b0;
            end
            if (hp_stb && sample_valid_o && !sample_ready_i) overrun_o <= 1'b1;
            else if (clear_overrun_i) overrun_o <= 1'b0;
        end
    end
endmodule

// File: doc/mockingboard_audio_conditioner.md
# mockingboard_audio_conditioner

Downstream audio stage for the Mockingboard card. It takes the two unsigned 10-bit per-side PSG channel sums and boxcar-decimates them from the bus-rate CE into an audio sample stream. It removes the DC offset with a first-order high-pass, applies a 4-bit volume, and saturates the result to signed 16-bit. Samples are presented to the audio output path (I2S/HDMI mixer) through a one-deep valid/ready output register.

## Interface
Parameters:
- DECIM_LOG2, default 4: window length is 2^DECIM_LOG2 CE pulses.
- DC_SHIFT, default 8: high-pass time constant, 2^DC_SHIFT output samples.
- GAIN_SHIFT, default 1: extra left shift applied after the volume multiply.

Ports:
- clk_logic  in  1  logic clock; all state on its rising edge.
- system_reset_n  in  1  asynchronous, active-low reset.
- ce_i  in  1  input sample strobe, one clk wide (phi1_negedge).
- enable_i  in  1  card enable; low holds the datapath idle.
- audio_l_i  in  10  left PSG sum, unsigned, 0..765.
- audio_r_i  in  10  right PSG sum, unsigned, 0..765.
- vol_i  in  4  volume, 0 = mute, 15 = max.
- dc_en_i  in  1  1 = high-pass active; 0 = bypass (hp = avg).
- sample_l_o  out  16  signed left output sample.
- sample_r_o  out  16  signed right output sample.
- sample_valid_o  out  1  output sample held valid.
- sample_ready_i  in  1  consumer accepts on valid && ready.
- overrun_o  out  1  sticky: an unconsumed sample was overwritten.
- clear_overrun_i  in  1  clears overrun_o.

## Operation
- Reset values: every output is 0. Accumulators, window counter, DC accumulators and pipeline strobes are also 0.
- Accumulate stage, per side: acc is (10+DECIM_LOG2) bits; cnt is DECIM_LOG2 bits.
  - On ce_i && enable_i: acc += audio_i and cnt++.
  - When cnt == 2^DECIM_LOG2-1 on that CE: avg <= (acc + audio_i) >> DECIM_LOG2 (floor, 10 bits), acc <= 0, cnt <= 0, avg_stb <= 1.
- enable_i low:
  - acc and cnt are forced to 0 and no avg_stb is produced.
  - DC state and the output register hold.
  - A partial window is discarded.
- High-pass stage, on avg_stb:
  - dc_acc is an unsigned accumulator of 10+DC_SHIFT bits; dc = dc_acc >> DC_SHIFT.
  - dc_en_i = 1: hp <= avg - dc (signed 11-bit) and dc_acc <= dc_acc + avg - dc. The new dc_acc stays ≤ 1023·2^DC_SHIFT, so it cannot overflow.
  - dc_en_i = 0: hp <= avg (zero-extended) and dc_acc holds.
  - hp_stb <= 1.
- Gain stage, on hp_stb:
  - p = (hp * vol_i) << GAIN_SHIFT, signed, at least 17 bits.
  - Clamp to [-32768, 32767] and load sample_*_o.
- Output handshake:
  - A transfer occurs on the rising edge where sample_valid_o && sample_ready_i.
  - sample_valid_o clears after a transfer unless a new sample loads on the same edge.
  - A new sample arriving while valid && !ready overwrites the data, keeps valid high and sets overrun_o.
  - Data is stable whenever valid is high and no new sample loads.
- overrun_o:
  - Cleared by clear_overrun_i.
  - If a set event and clear_overrun_i occur on the same edge, set wins.
- Left and right always move in lockstep: one shared cnt and shared strobes.

## Timing
- Latency: the completing ce_i is sampled at edge E. avg updates at E, hp at E+1, and sample_*_o/sample_valid_o at E+2. Valid is visible in the cycle after E+2.
- Throughput: one sample per 2^DECIM_LOG2 CEs. With the default of 16 at a ~1.02 MHz CE, that is ~63.9 kHz. The pipeline never stalls: new data is never blocked, only overwritten.
- Simultaneous load and transfer on the same edge: the transfer completes, the new sample loads with valid held at 1, and there is no overrun.
- ce_i pulses wider than one clk are out of contract.
- Reset asserted mid-window asynchronously clears all state. The first sample after release needs a full 2^DECIM_LOG2 CEs.
- vol_i, dc_en_i and GAIN_SHIFT-related inputs are sampled at the stage that uses them. No settling is required.

## Test plan
- Constant input: audio_l=765, audio_r=300, dc_en=0, vol=15, defaults, 16 CEs. Required: 3 edges after the 16th CE, valid=1, L=22950, R=9000.
- Averaging: 16 CEs alternating audio_l=0/1023, dc_en=0, vol=1. Required: avg floor(8184/16)=511, L=1022.
- DC removal: audio_l fixed 600, dc_en=1, vol=1, DC_SHIFT=4.
  - Required: first L=1200, decreasing monotonically.
  - After 200 samples, |L| ≤ 2*15 = 30: dc_acc settles within 2^DC_SHIFT−1 of 600·2^DC_SHIFT, so residual hp ≤ 15.
- Handshake/overrun: ready=0 across two windows. Required: overrun_o=1 and the second sample is held. Raise ready for 1 cycle: valid drops. Pulse clear_overrun_i: overrun_o=0. Clear coincident with a new overrun: overrun_o stays 1.
- Saturation: GAIN_SHIFT=2, dc_en=0, audio=1023 forced, vol=15. Required: L=32767. With DC_SHIFT state preloaded to 1023 and audio=0: L=-32768.
- Reset/enable: assert system_reset_n low after 7 CEs. Required: all outputs 0 immediately, and the next valid only after 16 further CEs. With enable_i low, no valid ever appears.
